// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive deframer.
// UART_RX_PARITY_EN adds the even-parity state to the state enum.
package uart_rx_pkg;

   localparam int unsigned DEF_CLKS_PER_BIT = 16;
   localparam int unsigned HALF_BIT         = DEF_CLKS_PER_BIT / 2;

   // Required XOR of data bits and parity bit for an even-parity frame.
   localparam logic PARITY_EVEN = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAIT_IDLE
`ifdef UART_RX_PARITY_EN
      , ST_PARITY
`endif
   } state_t;

   // Bits needed to hold values 0 .. n-1.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; a push while full is accepted
// only when a pop frees the head in the same cycle.
module uart_rx_fifo
   import uart_rx_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
)
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = cnt_w(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         mem    <= '{default: '0};
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receiver: synchronises serial_in, deframes 8N1 (or 8E1 with
// UART_RX_PARITY_EN defined) frames and buffers bytes in a FWFT FIFO.
module uart_rx_deframer
   import uart_rx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned FIFO_DEPTH   = 4
)
(
   input  logic                          PCLK,
   input  logic                          PRESETn,
   input  logic                          serial_in,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          busy,
   output logic                          frame_err,
   output logic                          parity_err,
   output logic                          overrun,
   input  logic                          clr_err
);

   localparam int unsigned HALF = CLKS_PER_BIT / 2;
   localparam int unsigned CW   = cnt_w(CLKS_PER_BIT);
   localparam int unsigned IW   = cnt_w(DATA_BITS);

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_bad_q, par_bad_d;
   logic                 sync1, line_s, line_prev;
   logic                 tick;
   logic                 push_c;
   logic                 ferr_d, perr_d;
   logic                 pop;
   logic                 full;
   logic                 empty;

   assign rx_valid = !empty;
   assign pop      = rx_valid && rx_ready;

   // Two-flop synchroniser plus previous-sample flop for edge detection.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         sync1     <= 1'b1;
         line_s    <= 1'b1;
         line_prev <= 1'b1;
      end else begin
         sync1     <= serial_in;
         line_s    <= sync1;
         line_prev <= line_s;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         shift_q    <= '0;
         par_bad_q  <= 1'b0;
         busy       <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         par_bad_q  <= par_bad_d;
         busy       <= (state_d != ST_IDLE);
         frame_err  <= ferr_d;
         parity_err <= perr_d;
      end
   end

   // Next-state logic: every sampling state counts down to a mid-bit tick.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      par_bad_d = par_bad_q;
      push_c    = 1'b0;
      ferr_d    = 1'b0;
      perr_d    = 1'b0;
      tick      = (cnt_q == '0);

      case (state_q)
         ST_IDLE: begin
            if (line_prev && !line_s) begin
               state_d   = ST_START;
               cnt_d     = CW'(HALF - 1);
               par_bad_d = 1'b0;
            end
         end
         ST_START: begin
            if (!tick) begin
               cnt_d = cnt_q - CW'(1);
            end else if (line_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DATA;
               cnt_d   = CW'(CLKS_PER_BIT - 1);
               idx_d   = '0;
            end
         end
         ST_DATA: begin
            if (!tick) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               shift_d = {line_s, shift_q[DATA_BITS-1:1]};
               cnt_d   = CW'(CLKS_PER_BIT - 1);
               if (idx_q == IW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (!tick) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               state_d = ST_STOP;
               cnt_d   = CW'(CLKS_PER_BIT - 1);
               if ((^shift_q ^ line_s) != PARITY_EVEN) begin
                  perr_d    = 1'b1;
                  par_bad_d = 1'b1;
               end
            end
         end
`endif
         ST_STOP: begin
            if (!tick) begin
               cnt_d = cnt_q - CW'(1);
            end else if (line_s) begin
               state_d = ST_IDLE;
               push_c  = !par_bad_q;
            end else begin
               state_d = ST_WAIT_IDLE;
               ferr_d  = 1'b1;
            end
         end
         ST_WAIT_IDLE: begin
            if (line_s) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Overrun: a good byte lost to a full FIFO; a new loss beats clr_err.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         overrun <= 1'b0;
      end else begin
         overrun <= (overrun && !clr_err) || (push_c && full && !pop);
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk   (PCLK),
      .rst_n (PRESETn),
      .push  (push_c),
      .wdata (shift_q),
      .pop   (pop),
      .rdata (rx_data),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: frame-level stimulus with a
// queue-based FIFO/overrun reference model.
module tb_uart_rx_deframer;

   localparam int unsigned CPB   = 16;
   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned HALF  = CPB / 2;
`ifdef UART_RX_PARITY_EN
   localparam int unsigned PB = 1;
`else
   localparam int unsigned PB = 0;
`endif
   // Stop-bit centre relative to the start edge, plus sync/edge-detect slack.
   localparam int LAT_MIN = int'((1 + DW + PB) * CPB + HALF);
   localparam int LAT_MAX = LAT_MIN + 4;

   logic          PCLK = 1'b0;
   logic          PRESETn = 1'b0;
   logic          serial_in = 1'b1;
   logic          rx_ready = 1'b0;
   logic          clr_err = 1'b0;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic [2:0]    fifo_count;
   logic          busy;
   logic          frame_err;
   logic          parity_err;
   logic          overrun;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int ferr_n = 0;
   int perr_n = 0;
   int rise_cyc = -1;
   int fall_cyc = -1;
   int lat = LAT_MIN + 3;
   logic pv = 1'b0;
   logic pb = 1'b0;

   uart_rx_deframer #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (DW),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .PCLK       (PCLK),
      .PRESETn    (PRESETn),
      .serial_in  (serial_in),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .fifo_count (fifo_count),
      .busy       (busy),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun    (overrun),
      .clr_err    (clr_err)
   );

   always #5 PCLK = ~PCLK;

   always @(posedge PCLK) cyc <= cyc + 1;

   always @(negedge PCLK) begin
      ferr_n <= ferr_n + ((frame_err === 1'b1) ? 1 : 0);
      perr_n <= perr_n + ((parity_err === 1'b1) ? 1 : 0);
      if (rx_valid === 1'b1 && !pv) rise_cyc <= cyc;
      if (busy === 1'b0 && pb) fall_cyc <= cyc;
      pv <= (rx_valid === 1'b1);
      pb <= (busy === 1'b1);
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge PCLK);
         #1;
      end
   endtask

   task automatic drive_bit(input logic v);
      serial_in = v;
      repeat (CPB) @(posedge PCLK);
      #1;
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input logic stop_v, input logic par_flip);
      drive_bit(1'b0);
      for (int i = 0; i < int'(DW); i++) drive_bit(d[i]);
      if (PB != 0) drive_bit((^d) ^ par_flip);
      drive_bit(stop_v);
      serial_in = 1'b1;
   endtask

   task automatic pop_one;
      rx_ready = 1'b1;
      idle(1);
      rx_ready = 1'b0;
   endtask

   task automatic pulse_clr;
      clr_err = 1'b1;
      idle(1);
      clr_err = 1'b0;
   endtask

   task automatic test_reset;
      PRESETn = 1'b0;
      idle(3);
      tests++;
      if ({rx_data, rx_valid, fifo_count, busy, frame_err, parity_err, overrun} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got data=%h valid=%b cnt=%0d busy=%b ferr=%b perr=%b ovr=%b expected all 0",
                  rx_data, rx_valid, fifo_count, busy, frame_err, parity_err, overrun);
      end
      PRESETn = 1'b1;
      idle(4);
   endtask

   task automatic test_reset_mid;
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      serial_in = 1'b1;
      PRESETn = 1'b0;
      idle(2);
      PRESETn = 1'b1;
      idle(12 * CPB);
      tests++;
      if ({busy, rx_valid, fifo_count} !== '0) begin
         fails++;
         $display("FAIL reset_mid: got busy=%b valid=%b cnt=%0d expected 0 0 0", busy, rx_valid, fifo_count);
      end
   endtask

   task automatic test_single;
      int start;
      int f0;
      int p0;
      int d;
      f0 = ferr_n;
      p0 = perr_n;
      start = cyc;
      send_frame(8'hA5, 1'b1, 1'b0);
      idle(1);
      d = rise_cyc - start;
      tests++;
      if (rx_data !== 8'hA5) begin
         fails++;
         $display("FAIL single_data: got %h expected a5", rx_data);
      end
      tests++;
      if (fifo_count !== 3'd1) begin
         fails++;
         $display("FAIL single_count: got %0d expected 1", fifo_count);
      end
      tests++;
      if (d < LAT_MIN || d > LAT_MAX) begin
         fails++;
         $display("FAIL single_latency: got %0d expected %0d..%0d", d, LAT_MIN, LAT_MAX);
      end else begin
         lat = d;
      end
      tests++;
      if (rise_cyc !== fall_cyc) begin
         fails++;
         $display("FAIL single_valid_vs_idle: got valid rise %0d expected busy fall %0d", rise_cyc, fall_cyc);
      end
      tests++;
      if (ferr_n != f0 || perr_n != p0) begin
         fails++;
         $display("FAIL single_errors: got %0d/%0d pulses expected 0/0", ferr_n - f0, perr_n - p0);
      end
      pop_one();
      tests++;
      if (rx_valid !== 1'b0) begin
         fails++;
         $display("FAIL single_pop: got valid=%b expected 0", rx_valid);
      end
   endtask

   task automatic test_overrun;
      logic [DW-1:0] exp;
      for (int i = 1; i <= 5; i++) begin
         send_frame(DW'(i), 1'b1, 1'b0);
         idle(2);
      end
      tests++;
      if (fifo_count !== 3'd4 || overrun !== 1'b1) begin
         fails++;
         $display("FAIL ovr_set: got cnt=%0d ovr=%b expected 4 1", fifo_count, overrun);
      end
      pulse_clr();
      tests++;
      if (overrun !== 1'b0) begin
         fails++;
         $display("FAIL ovr_clear: got %b expected 0", overrun);
      end
      fork
         send_frame(8'h06, 1'b1, 1'b0);
         begin
            repeat (lat - 1) @(posedge PCLK);
            #1;
            clr_err = 1'b1;
            idle(1);
            clr_err = 1'b0;
         end
      join
      idle(2);
      tests++;
      if (overrun !== 1'b1 || fifo_count !== 3'd4) begin
         fails++;
         $display("FAIL ovr_set_wins: got ovr=%b cnt=%0d expected 1 4", overrun, fifo_count);
      end
      for (int i = 1; i <= 4; i++) begin
         exp = DW'(i);
         tests++;
         if (rx_valid !== 1'b1 || rx_data !== exp) begin
            fails++;
            $display("FAIL ovr_order: got valid=%b data=%h expected 1 %h", rx_valid, rx_data, exp);
         end
         pop_one();
      end
      pulse_clr();
      tests++;
      if ({rx_valid, overrun, fifo_count} !== '0) begin
         fails++;
         $display("FAIL ovr_drained: got valid=%b ovr=%b cnt=%0d expected 0 0 0", rx_valid, overrun, fifo_count);
      end
   endtask

   task automatic test_break;
      int f0;
      f0 = ferr_n;
      send_frame(8'h3C, 1'b0, 1'b0);
      serial_in = 1'b0;
      idle(40 * CPB);
      tests++;
      if (busy !== 1'b1 || ferr_n - f0 != 1 || fifo_count !== 3'd0) begin
         fails++;
         $display("FAIL break_low: got busy=%b ferr_pulses=%0d cnt=%0d expected 1 1 0", busy, ferr_n - f0, fifo_count);
      end
      serial_in = 1'b1;
      idle(3 * CPB);
      tests++;
      if (busy !== 1'b0 || ferr_n - f0 != 1 || fifo_count !== 3'd0) begin
         fails++;
         $display("FAIL break_release: got busy=%b ferr_pulses=%0d cnt=%0d expected 0 1 0", busy, ferr_n - f0, fifo_count);
      end
   endtask

   task automatic test_glitch;
      int f0;
      int p0;
      f0 = ferr_n;
      p0 = perr_n;
      serial_in = 1'b0;
      idle(4);
      serial_in = 1'b1;
      idle(2 * CPB);
      tests++;
      if (busy !== 1'b0 || fifo_count !== 3'd0 || ferr_n != f0 || perr_n != p0) begin
         fails++;
         $display("FAIL glitch: got busy=%b cnt=%0d errs=%0d/%0d expected 0 0 0/0",
                  busy, fifo_count, ferr_n - f0, perr_n - p0);
      end
   endtask

   task automatic test_full_pop;
      logic [DW-1:0] q[$];
      logic [DW-1:0] b;
      for (int i = 0; i < int'(DEPTH); i++) begin
         b = DW'($urandom);
         q.push_back(b);
         send_frame(b, 1'b1, 1'b0);
         idle(1);
      end
      b = DW'($urandom);
      fork
         send_frame(b, 1'b1, 1'b0);
         begin
            repeat (lat - 1) @(posedge PCLK);
            #1;
            rx_ready = 1'b1;
            idle(1);
            rx_ready = 1'b0;
         end
      join
      void'(q.pop_front());
      q.push_back(b);
      idle(2);
      tests++;
      if (fifo_count !== 3'd4 || overrun !== 1'b0) begin
         fails++;
         $display("FAIL fullpop_state: got cnt=%0d ovr=%b expected 4 0", fifo_count, overrun);
      end
      while (q.size() > 0) begin
         tests++;
         if (rx_data !== q[0]) begin
            fails++;
            $display("FAIL fullpop_order: got %h expected %h", rx_data, q[0]);
         end
         void'(q.pop_front());
         pop_one();
      end
   endtask

   task automatic test_random;
      logic [DW-1:0] q[$];
      logic [DW-1:0] b;
      logic ovr;
      int n;
      for (int r = 0; r < 3; r++) begin
         q.delete();
         ovr = 1'b0;
         n = int'($urandom_range(6, 1));
         for (int k = 0; k < n; k++) begin
            b = DW'($urandom);
            if (q.size() < int'(DEPTH)) q.push_back(b);
            else ovr = 1'b1;
            send_frame(b, 1'b1, 1'b0);
            idle(int'($urandom_range(3, 0)));
         end
         idle(2);
         tests++;
         if (fifo_count !== 3'(q.size()) || overrun !== ovr) begin
            fails++;
            $display("FAIL rand_state: got cnt=%0d ovr=%b expected %0d %b", fifo_count, overrun, q.size(), ovr);
         end
         while (q.size() > 0) begin
            tests++;
            if (rx_valid !== 1'b1 || rx_data !== q[0]) begin
               fails++;
               $display("FAIL rand_data: got valid=%b data=%h expected 1 %h", rx_valid, rx_data, q[0]);
            end
            void'(q.pop_front());
            pop_one();
         end
         pop_one();
         pulse_clr();
         tests++;
         if ({rx_valid, fifo_count, overrun} !== '0) begin
            fails++;
            $display("FAIL rand_empty_pop: got valid=%b cnt=%0d ovr=%b expected 0 0 0", rx_valid, fifo_count, overrun);
         end
      end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity;
      int f0;
      int p0;
      f0 = ferr_n;
      p0 = perr_n;
      send_frame(8'h07, 1'b1, 1'b1);
      idle(2);
      tests++;
      if (perr_n - p0 != 1 || fifo_count !== 3'd0 || ferr_n != f0) begin
         fails++;
         $display("FAIL parity_bad: got perr=%0d cnt=%0d ferr=%0d expected 1 0 0", perr_n - p0, fifo_count, ferr_n - f0);
      end
      send_frame(8'h07, 1'b1, 1'b0);
      idle(2);
      tests++;
      if (perr_n - p0 != 1 || fifo_count !== 3'd1 || rx_data !== 8'h07) begin
         fails++;
         $display("FAIL parity_good: got perr=%0d cnt=%0d data=%h expected 1 1 07", perr_n - p0, fifo_count, rx_data);
      end
      pop_one();
   endtask
`endif

   initial begin
      test_reset();
      test_reset_mid();
      test_single();
      test_overrun();
      test_break();
      test_glitch();
      test_full_pop();
      test_random();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Downstream stage of the APB GPIO/UART top level. Consumes the top's serial_out line.
- Deserialises 8N1 UART frames into bytes and buffers them in a small FIFO.
- Presents bytes on a valid/ready interface to a checker or host-side consumer, with framing, parity and overrun reporting.

Parameters:
- CLKS_PER_BIT, 16, PCLK cycles per UART bit; even, ≥4.
- DATA_BITS, 8, data bits per frame, LSB first.
- FIFO_DEPTH, 4, receive FIFO entries; power of two.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous active-low reset.
- serial_in  in  1  UART line; idle high; driven by the top's serial_out.
- rx_data  out  DATA_BITS  FIFO head byte.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer accepts the head when rx_valid && rx_ready.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- busy  out  1  state != IDLE.
- frame_err  out  1  one-cycle pulse when the stop bit samples 0.
- parity_err  out  1  one-cycle pulse on parity mismatch.
- overrun  out  1  sticky; set when a good byte arrives with the FIFO full.
- clr_err  in  1  clears overrun.

Behaviour:
- Reset values: all outputs 0. The synchroniser flops reset to 1 (idle line). The state machine resets to IDLE and the FIFO is emptied.
- Reset mid-frame: the partial frame is discarded.
- Input path: 2-flop synchroniser produces line_s. All sampling uses line_s. The consumer sees a fixed 2-cycle input latency.
- States: IDLE, START, DATA, PARITY (feature only), STOP, WAIT_IDLE.
- One baud counter (bit_cnt_clk) and one bit index (bit_idx).
- IDLE: a high→low transition on line_s moves to START and loads the counter.
- START: after CLKS_PER_BIT/2 cycles, resample line_s.
  - Line = 1: glitch; return to IDLE with no error.
  - Line = 0: go to DATA.
- DATA: sample every CLKS_PER_BIT cycles, i.e. at mid-bit. Shift in LSB first. After DATA_BITS samples, go to PARITY or STOP.
- STOP: sample at mid-bit.
  - 1: push the byte to the FIFO and return to IDLE.
  - 0: pulse frame_err, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until line_s = 1, then go to IDLE. This absorbs a break condition without generating further frames.
- Latency: the push happens on the edge at which the stop bit is sampled. rx_valid rises the following cycle.
- FIFO ordering: first-word-fall-through. rx_data is valid whenever rx_valid = 1.
- Push when full:
  - Without a simultaneous pop: the byte is dropped, overrun is set, and FIFO contents are unchanged.
  - With a simultaneous pop in the same cycle: both happen, no overrun, fifo_count stays at FIFO_DEPTH.
- Pop when empty: ignored.
- Pointers: wrap modulo FIFO_DEPTH.
- clr_err vs overrun: clr_err clears overrun. If clr_err and a new overrun occur in the same cycle, set wins.
- Error bytes: frame_err and parity_err bytes are never pushed.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - The frame carries one even-parity bit after the data bits; PARITY is sampled at mid-bit.
  - The check is XOR(data, parity) = 0.
  - On mismatch: pulse parity_err in the PARITY-sample cycle, still check the stop bit, and discard the byte regardless of the stop bit.
  - If the stop bit is also 0, frame_err additionally pulses in the stop-sample cycle.
- Undefined: the PARITY state is absent, the frame is 8N1, and parity_err is tied 0.

Decomposition:
- Package uart_rx_pkg:
  - state enum;
  - HALF_BIT constant (CLKS_PER_BIT/2);
  - counter-width function;
  - PARITY_EVEN constant.
- Sub-module uart_rx_fifo: parameterised depth/width, FWFT, push/pop/full/empty/count. The top-level FSM instantiates it.

Test Plan:
- Send 0xA5 at CLKS_PER_BIT=16 -> rx_data=0xA5, rx_valid rises 1 cycle after the stop sample, fifo_count=1, no error pulses.
- Send 0x01,0x02,0x03,0x04,0x05 with rx_ready=0 (depth 4) -> FIFO holds 01..04 and overrun=1. Pop order 01,02,03,04. clr_err then clears overrun.
- Frame 0x3C with stop bit forced 0, line held low 40 bit-times, then idle -> one frame_err pulse, no push, busy stays high until the line returns high, and no spurious frames.
- Low glitch of 4 cycles on the idle line -> returns to IDLE with no push and no errors.
- FIFO full plus a new byte arriving in the same cycle as rx_ready=1 -> no overrun, count stays 4, new byte at the tail.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 0 (wrong) -> parity_err pulse, no push. Send 0x07 with parity bit 1 -> byte pushed.
